// File: rtl/clock_run_controller_pkg.sv
// Shared processor-clocking definitions: run-controller state encodings,
// divisor width and the default divisor constants.
package clock_run_controller_pkg;

  localparam int DIV_W = 28;

  localparam logic [DIV_W-1:0] DEF_DIV0 = 28'd1;
  localparam logic [DIV_W-1:0] DEF_DIV1 = 28'd50_000;
  localparam logic [DIV_W-1:0] DEF_DIV2 = 28'd5_000_000;
  localparam logic [DIV_W-1:0] DEF_DIV3 = 28'd250_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  function automatic logic [DIV_W-1:0] div_pick(
    input logic [1:0]       sel,
    input logic [DIV_W-1:0] d0,
    input logic [DIV_W-1:0] d1,
    input logic [DIV_W-1:0] d2,
    input logic [DIV_W-1:0] d3
  );
    logic [DIV_W-1:0] res;
    case (sel)
      2'd0:    res = d0;
      2'd1:    res = d1;
      2'd2:    res = d2;
      default: res = d3;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/clock_tick_counter.sv
// Free-running 28-bit divider counter: counts while enabled, wraps to zero
// and flags a tick when it reaches the terminal value.
module clock_tick_counter
  import clock_run_controller_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] terminal_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = enable_i && (cnt_q == terminal_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_run_controller.sv
// Processor run/step/halt controller issuing registered one-cycle clock-enable
// pulses at a selectable divided rate, with a running pulse count.
module clock_run_controller
  import clock_run_controller_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV0 = DEF_DIV0,
  parameter logic [DIV_W-1:0] DIV1 = DEF_DIV1,
  parameter logic [DIV_W-1:0] DIV2 = DEF_DIV2,
  parameter logic [DIV_W-1:0] DIV3 = DEF_DIV3
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic [1:0]  div_sel,
  output logic        clk_en,
  output logic [1:0]  state,
  output logic        busy,
  output logic [15:0] tick_count
);

  run_state_e       state_q;
  run_state_e       state_d;
  logic [DIV_W-1:0] div_reg_q;
  logic             step_d_q;
  logic             step_armed_q;
  logic             clk_en_q;
  logic             clk_en_d;
  logic [15:0]      tick_count_q;

  logic             step_rise;
  logic             cnt_enable;
  logic             cnt_tick;
  logic [DIV_W-1:0] terminal;

  // The arm flag keeps a step still held high across reset from counting as
  // a new edge; the step must be seen low once first.
  assign step_rise  = step && !step_d_q && step_armed_q;
  assign cnt_enable = (state_q == ST_RUN) && run && !halt_req;
  assign terminal   = div_reg_q - 1'b1;

  clock_tick_counter u_counter (
    .clk_i      (clock_in),
    .rst_i      (reset),
    .clear_i    (!cnt_enable),
    .enable_i   (cnt_enable),
    .terminal_i (terminal),
    .tick_o     (cnt_tick)
  );

  always_comb begin
    state_d  = state_q;
    clk_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_rise) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (!run) begin
          state_d = ST_IDLE;
        end else begin
          clk_en_d = cnt_tick;
        end
      end
      ST_STEP: begin
        clk_en_d = 1'b1;
        state_d  = halt_req ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        if (!run && !step) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_reg_q    <= DIV0;
      step_d_q     <= 1'b0;
      step_armed_q <= 1'b0;
      clk_en_q     <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      step_d_q     <= step;
      step_armed_q <= step_armed_q | ~step;
      clk_en_q     <= clk_en_d;
      if (state_q == ST_IDLE) begin
        div_reg_q <= div_pick(div_sel, DIV0, DIV1, DIV2, DIV3);
      end
      if (clk_en_d) begin
        tick_count_q <= tick_count_q + 16'd1;
      end
    end
  end

  assign clk_en     = clk_en_q;
  assign state      = state_q;
  assign busy       = (state_q != ST_IDLE);
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_clock_run_controller.sv
// Self-checking bench for clock_run_controller: expected clk_en pulse cycles
// are queued as stimulus is driven and matched as pulses appear.
module tb_clock_run_controller;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [1:0]  div_sel;
  logic        clk_en;
  logic [1:0]  state;
  logic        busy;
  logic [15:0] tick_count;

  int unsigned cyc;
  int unsigned total_cnt;
  int unsigned bad_cnt;
  int unsigned exp_ticks;
  logic [31:0] exp_q[$];

  clock_run_controller #(
    .DIV0 (28'd1),
    .DIV1 (28'd4),
    .DIV2 (28'd7),
    .DIV3 (28'd11)
  ) dut (
    .clock_in   (clk),
    .reset      (rst),
    .run        (run),
    .step       (step),
    .halt_req   (halt_req),
    .div_sel    (div_sel),
    .clk_en     (clk_en),
    .state      (state),
    .busy       (busy),
    .tick_count (tick_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: every clk_en pulse must match the oldest expected cycle
  always @(negedge clk) begin
    if (clk_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_pulse", cyc, 32'd0);
      end else begin
        check_val("pulse_cyc", cyc, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // run entered at the edge after `start`; pulses every d cycles after that
  task automatic push_run(input int unsigned start, input int unsigned d, input int count);
    for (int k = 1; k <= count; k++) begin
      exp_q.push_back(start + 1 + k * d);
    end
    exp_ticks += count;
  endtask

  initial begin
    int unsigned n;
    int unsigned m;
    int unsigned r;
    total_cnt = 0;
    bad_cnt   = 0;
    exp_ticks = 0;
    rst       = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    halt_req  = 1'b0;
    div_sel   = 2'd0;

    wait_cyc(2);
    check_val("rst_clk_en", clk_en, 0);
    check_val("rst_state", state, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ticks", tick_count, 0);
    rst = 1'b0;
    wait_cyc(3);

    // free run at DIV1=4
    n = cyc;
    div_sel = 2'd1;
    run = 1'b1;
    push_run(n, 4, 3);
    goto_cyc(n + 13);
    check_val("run_ticks", tick_count, exp_ticks);
    check_val("run_state", state, 1);
    check_val("run_busy", busy, 1);
    run = 1'b0;
    wait_cyc(1);
    check_val("run_stop_state", state, 0);
    wait_cyc(3);

    // single step with step held high for 10 cycles
    n = cyc;
    step = 1'b1;
    exp_q.push_back(n + 2);
    exp_ticks++;
    wait_cyc(1);
    check_val("step_state", state, 2);
    wait_cyc(1);
    check_val("step_back_idle", state, 0);
    goto_cyc(n + 10);
    check_val("step_held_state", state, 0);
    check_val("step_ticks", tick_count, exp_ticks);
    step = 1'b0;
    wait_cyc(2);
    n = cyc;
    step = 1'b1;
    exp_q.push_back(n + 2);
    exp_ticks++;
    wait_cyc(3);
    step = 1'b0;
    check_val("step2_ticks", tick_count, exp_ticks);
    wait_cyc(2);

    // halt when counter is at terminal value
    n = cyc;
    div_sel = 2'd1;
    run = 1'b1;
    push_run(n, 4, 1);
    goto_cyc(n + 8);
    halt_req = 1'b1;
    wait_cyc(1);
    halt_req = 1'b0;
    check_val("halt_state", state, 3);
    wait_cyc(3);
    check_val("halt_hold_state", state, 3);
    check_val("halt_busy", busy, 1);
    run = 1'b0;
    wait_cyc(1);
    check_val("halt_exit_state", state, 0);
    check_val("halt_ticks", tick_count, exp_ticks);
    wait_cyc(2);

    // div_sel changed during run is ignored, then used on re-run
    n = cyc;
    div_sel = 2'd0;
    run = 1'b1;
    push_run(n, 1, 9);
    goto_cyc(n + 3);
    div_sel = 2'd3;
    goto_cyc(n + 10);
    run = 1'b0;
    wait_cyc(2);
    check_val("sel_idle_state", state, 0);
    m = cyc;
    run = 1'b1;
    push_run(m, 11, 3);
    goto_cyc(m + 34);
    run = 1'b0;
    wait_cyc(2);
    check_val("sel_ticks", tick_count, exp_ticks);

    // tick_count wrap with DIV0 pulses every cycle
    r = 65536 - (exp_ticks % 65536);
    n = cyc;
    div_sel = 2'd0;
    run = 1'b1;
    push_run(n, 1, int'(r) + 1);
    goto_cyc(n + r);
    check_val("wrap_pre", tick_count, 32'hFFFF);
    goto_cyc(n + r + 1);
    check_val("wrap_zero", tick_count, 0);
    goto_cyc(n + r + 2);
    run = 1'b0;
    check_val("wrap_one", tick_count, 1);
    wait_cyc(2);

    // asynchronous reset mid-run, step held across reset
    n = cyc;
    div_sel = 2'd0;
    run = 1'b1;
    push_run(n, 1, 4);
    goto_cyc(n + 5);
    #2;
    rst = 1'b1;
    run = 1'b0;
    step = 1'b1;
    #1;
    check_val("arst_clk_en", clk_en, 0);
    check_val("arst_state", state, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_ticks", tick_count, 0);
    exp_ticks = 0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(5);
    check_val("post_rst_step_state", state, 0);
    step = 1'b0;
    wait_cyc(1);
    n = cyc;
    step = 1'b1;
    exp_q.push_back(n + 2);
    exp_ticks++;
    wait_cyc(3);
    step = 1'b0;
    check_val("post_rst_ticks", tick_count, exp_ticks);
    wait_cyc(3);

    check_val("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
